// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for the single-port data memory.
// Port 0 is the core load/store path, port 1 is the loader; core_stall freezes the PC.
//
// state  | meaning
// IDLE   | arbitrate; on grant latch request and raise the strobe for the next cycle
// ACCESS | memory strobe asserted for this single cycle; load latency counter
// WAIT   | count down memory latency; capture read data when counter reaches 0
// RESP   | one-cycle ack to the granted port
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DM_ADDRESS = 9,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  we0,
    input  logic [DM_ADDRESS-1:0] addr0,
    input  logic [DATA_W-1:0]     wdata0,
    output logic                  ack0,
    output logic [DATA_W-1:0]     rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic [DM_ADDRESS-1:0] addr1,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  ack1,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  core_stall,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

    state_t                state, state_nxt;
    logic                  last_gnt, last_gnt_nxt;
    logic                  id, id_nxt;
    logic                  we_q, we_nxt;
    logic [2:0]            cnt, cnt_nxt;
    logic [DM_ADDRESS-1:0] addr_nxt;
    logic [DATA_W-1:0]     wdata_nxt;
    logic                  read_nxt, write_nxt;
    logic                  ack0_nxt, ack1_nxt;
    logic [DATA_W-1:0]     rdata0_nxt, rdata1_nxt;
    logic                  gnt1;
    logic                  we_sel;

    assign core_stall = req0 & ~ack0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            id        <= 1'b0;
            we_q      <= 1'b0;
            cnt       <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            state     <= state_nxt;
            last_gnt  <= last_gnt_nxt;
            id        <= id_nxt;
            we_q      <= we_nxt;
            cnt       <= cnt_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
            mem_read  <= read_nxt;
            mem_write <= write_nxt;
            ack0      <= ack0_nxt;
            ack1      <= ack1_nxt;
            rdata0    <= rdata0_nxt;
            rdata1    <= rdata1_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        last_gnt_nxt = last_gnt;
        id_nxt       = id;
        we_nxt       = we_q;
        cnt_nxt      = cnt;
        addr_nxt     = mem_addr;
        wdata_nxt    = mem_wdata;
        read_nxt     = 1'b0;
        write_nxt    = 1'b0;
        ack0_nxt     = 1'b0;
        ack1_nxt     = 1'b0;
        rdata0_nxt   = rdata0;
        rdata1_nxt   = rdata1;
        // Port 1 wins if it is alone, or if both request and port 0 was served last.
        gnt1         = req1 & (~req0 | ~last_gnt);
        we_sel       = gnt1 ? we1 : we0;

        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    id_nxt       = gnt1;
                    last_gnt_nxt = gnt1;
                    we_nxt       = we_sel;
                    addr_nxt     = gnt1 ? addr1 : addr0;
                    wdata_nxt    = gnt1 ? wdata1 : wdata0;
                    read_nxt     = ~we_sel;
                    write_nxt    = we_sel;
                    state_nxt    = ACCESS;
                end
            end
            ACCESS: begin
                cnt_nxt   = CNT_LOAD;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt == 3'd0) begin
                    if (!we_q) begin
                        if (id) rdata1_nxt = mem_rdata;
                        else    rdata0_nxt = mem_rdata;
                    end
                    ack0_nxt  = ~id;
                    ack1_nxt  = id;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at LATENCY=1, one at LATENCY=3.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, we0, req1, we1;
    logic [8:0]  addr0, addr1;
    logic [31:0] wdata0, wdata1, mem_rdata;
    logic        ack0, ack1, core_stall, mem_read, mem_write;
    logic [31:0] rdata0, rdata1, mem_wdata;
    logic [8:0]  mem_addr;

    logic        q_req0, q_we0, q_req1, q_we1;
    logic [8:0]  q_addr0, q_addr1;
    logic [31:0] q_wdata0, q_wdata1, q_mem_rdata;
    logic        q_ack0, q_ack1, q_core_stall, q_mem_read, q_mem_write;
    logic [31:0] q_rdata0, q_rdata1, q_mem_wdata;
    logic [8:0]  q_mem_addr;

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .core_stall(core_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req0(q_req0), .we0(q_we0), .addr0(q_addr0), .wdata0(q_wdata0), .ack0(q_ack0), .rdata0(q_rdata0),
        .req1(q_req1), .we1(q_we1), .addr1(q_addr1), .wdata1(q_wdata1), .ack1(q_ack1), .rdata1(q_rdata1),
        .core_stall(q_core_stall), .mem_read(q_mem_read), .mem_write(q_mem_write),
        .mem_addr(q_mem_addr), .mem_wdata(q_mem_wdata), .mem_rdata(q_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        logic p;
        reset = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        mem_rdata = '0;
        q_req0 = 1'b0; q_we0 = 1'b0; q_addr0 = '0; q_wdata0 = '0;
        q_req1 = 1'b0; q_we1 = 1'b0; q_addr1 = '0; q_wdata1 = '0;
        q_mem_rdata = '0;
        tick();

        // Reset held with both ports requesting
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h010;
        req1 = 1'b1; we1 = 1'b1; addr1 = 9'h1FC; wdata1 = 32'h12345678;
        mem_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ctrl", 32'({ack0, ack1, mem_read, mem_write}), 32'h0);
            chk("rst_rdata0", rdata0, 32'h0);
            chk("rst_rdata1", rdata1, 32'h0);
            chk("rst_addr", 32'(mem_addr), 32'h0);
            chk("rst_wdata", mem_wdata, 32'h0);
        end

        // Release: port 0 wins the first tie; load of DEADBEEF
        reset = 1'b1;
        chkb("stall_N", core_stall, 1'b1);
        tick();
        chkb("ld_read_N1", mem_read, 1'b1);
        chkb("ld_write_N1", mem_write, 1'b0);
        chk("ld_addr_N1", 32'(mem_addr), 32'h010);
        chkb("stall_N1", core_stall, 1'b1);
        tick();
        chkb("ld_read_N2", mem_read, 1'b0);
        chkb("ld_ack_N2", ack0, 1'b0);
        chkb("stall_N2", core_stall, 1'b1);
        tick();
        chkb("ld_ack_N3", ack0, 1'b1);
        chk("ld_rdata0", rdata0, 32'hDEADBEEF);
        chkb("stall_N3", core_stall, 1'b0);
        chkb("ld_ack1_N3", ack1, 1'b0);
        req0 = 1'b0;
        mem_rdata = 32'hBAD0BAD0;
        tick();
        chkb("ld_ack_N4", ack0, 1'b0);
        chk("ld_rdata0_hold", rdata0, 32'hDEADBEEF);

        // Port 1 store, waiting since reset release
        tick();
        chkb("st_write", mem_write, 1'b1);
        chkb("st_read", mem_read, 1'b0);
        chk("st_addr", 32'(mem_addr), 32'h1FC);
        chk("st_wdata", mem_wdata, 32'h12345678);
        tick();
        chkb("st_write_off", mem_write, 1'b0);
        chkb("st_ack_early", ack1, 1'b0);
        tick();
        chkb("st_ack1", ack1, 1'b1);
        chk("st_rdata1", rdata1, 32'h0);
        req1 = 1'b0;
        tick();
        chkb("st_ack1_off", ack1, 1'b0);

        // Contention: last grant was port 1, so order is 0,1,0,1
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h0AA;
        req1 = 1'b1; we1 = 1'b1; addr1 = 9'h155; wdata1 = 32'hCAFEF00D;
        for (int k = 0; k < 4; k++) begin
            p = k[0];
            mem_rdata = (k == 0) ? 32'h11112222 : 32'h33334444;
            tick();
            chk("ct_addr", 32'(mem_addr), p ? 32'h155 : 32'h0AA);
            chk("ct_strobe", 32'({mem_read, mem_write}), p ? 32'h1 : 32'h2);
            tick();
            chk("ct_wait", 32'({mem_read, mem_write, ack0, ack1}), 32'h0);
            tick();
            chk("ct_ack", 32'({ack0, ack1}), p ? 32'h1 : 32'h2);
            if (!p) chk("ct_rdata0", rdata0, (k == 0) ? 32'h11112222 : 32'h33334444);
            else    chk("ct_rdata1", rdata1, 32'h0);
            tick();
            chk("ct_idle", 32'({ack0, ack1, mem_read, mem_write}), 32'h0);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Abort: reset during WAIT of a port-0 load, port 1 pending
        req0 = 1'b1; we0 = 1'b0; addr0 = 9'h033;
        req1 = 1'b1; we1 = 1'b0; addr1 = 9'h044;
        tick();
        chk("ab_addr0", 32'(mem_addr), 32'h033);
        chkb("ab_read0", mem_read, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        chk("ab_ctrl", 32'({ack0, ack1, mem_read, mem_write}), 32'h0);
        chk("ab_rdata0", rdata0, 32'h0);
        req0 = 1'b0;
        reset = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        tick();
        chkb("ab_read1", mem_read, 1'b1);
        chk("ab_addr1", 32'(mem_addr), 32'h044);
        tick();
        chkb("ab_ack0_none", ack0, 1'b0);
        tick();
        chkb("ab_ack1", ack1, 1'b1);
        chkb("ab_ack0", ack0, 1'b0);
        chk("ab_rdata1", rdata1, 32'h5A5A5A5A);
        req1 = 1'b0;
        tick();
        chkb("ab_ack1_off", ack1, 1'b0);

        // LATENCY=3 instance: strobe at N+1, capture during N+4, ack at N+5
        q_req0 = 1'b1; q_we0 = 1'b0; q_addr0 = 9'h0F0;
        q_mem_rdata = 32'h0BADF00D;
        tick();
        chkb("l3_read", q_mem_read, 1'b1);
        chk("l3_addr", 32'(q_mem_addr), 32'h0F0);
        tick();
        chkb("l3_read_off", q_mem_read, 1'b0);
        q_mem_rdata = 32'h77777777;
        tick();
        chkb("l3_ack_N3", q_ack0, 1'b0);
        tick();
        chkb("l3_ack_N4", q_ack0, 1'b0);
        chkb("l3_stall_N4", q_core_stall, 1'b1);
        q_mem_rdata = 32'hFEEDFACE;
        tick();
        chkb("l3_ack_N5", q_ack0, 1'b1);
        chk("l3_rdata0", q_rdata0, 32'hFEEDFACE);
        chkb("l3_stall_N5", q_core_stall, 1'b0);
        q_req0 = 1'b0;
        tick();
        chkb("l3_ack_off", q_ack0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
